// File: rtl/shift_engine_if.sv
// Bundle between a control FSM, the shift engine and the downstream consumer.
// The master side drives the request and out_ready; the slave side is the engine.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] shamt;
  logic [CNT_W-1:0] iter;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, mode, shamt, iter, data_in, out_ready,
    input  busy, data_out, out_valid
  );

  modport slave (
    input  start, mode, shamt, iter, data_in, out_ready,
    output busy, data_out, out_valid
  );
endinterface

// File: rtl/shift_engine.sv
// Iterative shift/rotate engine: capture on start, shamt-step iter times, present on valid/ready.
// Define SHIFT_ENGINE_ROT_EN to build rotate-left for mode 11; otherwise mode 11 acts as LSL.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  shift_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_save;
  logic [WIDTH-1:0] r_data_out;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [AMT_W-1:0] r_shamt;
  logic             r_out_valid;

  logic             w_capture;
  logic             w_step;
  logic             w_finish;
  logic             w_accept;
  logic [WIDTH-1:0] w_lsl;
  logic [WIDTH-1:0] w_lsr;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_step_val;
`ifdef SHIFT_ENGINE_ROT_EN
  logic [31:0]      w_rot_amt;
  logic [WIDTH-1:0] w_rol;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_step = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shifts by >= WIDTH naturally yield zero (logical) or all sign bits (arithmetic).
  always_comb begin
    w_lsl = r_save << r_shamt;
    w_lsr = r_save >> r_shamt;
    w_asr = $signed(r_save) >>> r_shamt;
`ifdef SHIFT_ENGINE_ROT_EN
    w_rot_amt = 32'(r_shamt) % WIDTH;
    w_rol     = (r_save << w_rot_amt) | (r_save >> (WIDTH - w_rot_amt));
`endif
    case (r_mode)
      2'b01:   w_step_val = w_lsr;
      2'b10:   w_step_val = w_asr;
`ifdef SHIFT_ENGINE_ROT_EN
      2'b11:   w_step_val = w_rol;
`endif
      default: w_step_val = w_lsl;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_save      <= '0;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_shamt     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_save  <= bus.data_in;
        r_cnt   <= bus.iter;
        r_mode  <= bus.mode;
        r_shamt <= bus.shamt;
      end
      if (w_step) begin
        r_save <= w_step_val;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_data_out  <= r_save;
        r_out_valid <= 1'b1;
      end
      if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: 8-bit instance against a latency/arithmetic model,
// plus a 4-bit instance for shift amounts beyond the width. Honours SHIFT_ENGINE_ROT_EN.
module tb_shift_engine;

  logic clk = 1'b0;
  logic rst_n;
  bit   cmp_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  shift_engine_if #(.WIDTH(8), .AMT_W(3), .CNT_W(4)) se8 ();
  shift_engine_if #(.WIDTH(4), .AMT_W(3), .CNT_W(4)) se4 ();

  shift_engine #(.WIDTH(8), .AMT_W(3), .CNT_W(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (se8.slave)
  );

  shift_engine #(.WIDTH(4), .AMT_W(3), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (se4.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One shift step computed with plain integer arithmetic on a w-bit value.
  function automatic int unsigned model_step(input int unsigned x, input int m, input int s,
                                             input int w);
    int unsigned mask;
    int          v;
    int          k;
    int unsigned r;
    mask = (32'd1 << w) - 1;
`ifndef SHIFT_ENGINE_ROT_EN
    if (m == 3) m = 0;
`endif
    case (m)
      0: r = (s >= w) ? 0 : ((x << s) & mask);
      1: r = (s >= w) ? 0 : (x >> s);
      2: begin
        v = (x >= (32'd1 << (w - 1))) ? int'(x) - int'(32'd1 << w) : int'(x);
        for (int i = 0; i < s; i++) v = v >>> 1;
        r = int'(v) & mask;
      end
      default: begin
        k = s % w;
        r = x;
        for (int i = 0; i < k; i++) r = ((r << 1) | (r >> (w - 1))) & mask;
      end
    endcase
    return r;
  endfunction

  function automatic int unsigned model_result(input int unsigned x, input int m, input int s,
                                               input int n, input int w);
    int unsigned r;
    r = x;
    for (int i = 0; i < n; i++) r = model_step(r, m, s, w);
    return r;
  endfunction

  // Observable-behaviour model of the 8-bit instance: result ready iter+1 edges after start.
  logic       m_busy;
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_result;
  int         m_remain;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= 8'h00;
      m_result <= 8'h00;
      m_remain <= 0;
    end else if (!m_busy) begin
      if (se8.start) begin
        m_busy   <= 1'b1;
        m_remain <= int'(se8.iter) + 1;
        m_result <= 8'(model_result(se8.data_in, se8.mode, se8.shamt, se8.iter, 8));
      end
    end else if (!m_valid) begin
      if (m_remain == 1) begin
        m_valid <= 1'b1;
        m_data  <= m_result;
      end
      m_remain <= m_remain - 1;
    end else if (se8.out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_busy", 32'(se8.busy), 32'(m_busy));
        check("cyc_valid", 32'(se8.out_valid), 32'(m_valid));
        check("cyc_data", 32'(se8.data_out), 32'(m_data));
      end
    end
  end

  // Starts an 8-bit operation from a negedge, scrambles the inputs during RUN, waits for the
  // result, holds out_ready low for 'hold' cycles (pulsing start once) and then accepts.
  task automatic run_op(input logic [7:0] d, input logic [1:0] m, input logic [2:0] s,
                        input logic [3:0] it, input logic [7:0] exp, input int hold);
    int lat;
    se8.start   = 1'b1;
    se8.data_in = d;
    se8.mode    = m;
    se8.shamt   = s;
    se8.iter    = it;
    @(posedge clk);
    @(negedge clk);
    se8.start   = 1'b0;
    se8.data_in = ~d;
    se8.mode    = ~m;
    se8.shamt   = ~s;
    se8.iter    = ~it;
    lat = 0;
    while (!se8.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(it) + 1);
    check("result", 32'(se8.data_out), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      se8.start = (i == 2);
      @(negedge clk);
      check("hold_valid", 32'(se8.out_valid), 32'd1);
      check("hold_data", 32'(se8.data_out), 32'(exp));
    end
    se8.start     = 1'b0;
    se8.out_ready = 1'b1;
    @(negedge clk);
    se8.out_ready = 1'b0;
    check("accept_valid", 32'(se8.out_valid), 32'd0);
    check("accept_busy", 32'(se8.busy), 32'd0);
  endtask

  task automatic run4(input logic [3:0] d, input logic [1:0] m, input logic [2:0] s,
                      input logic [3:0] it, input logic [3:0] exp);
    int lat;
    se4.start   = 1'b1;
    se4.data_in = d;
    se4.mode    = m;
    se4.shamt   = s;
    se4.iter    = it;
    @(posedge clk);
    @(negedge clk);
    se4.start = 1'b0;
    lat = 0;
    while (!se4.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("w4_latency", 32'(lat), 32'(it) + 1);
    check("w4_result", 32'(se4.data_out), 32'(exp));
    se4.out_ready = 1'b1;
    @(negedge clk);
    se4.out_ready = 1'b0;
    check("w4_idle", 32'(se4.busy), 32'd0);
  endtask

  logic [7:0] exp_rol1;
  logic [7:0] exp_rol5;
  logic [3:0] exp_rol4;

  initial begin
`ifdef SHIFT_ENGINE_ROT_EN
    exp_rol1 = 8'h0C;
    exp_rol5 = 8'h30;
    exp_rol4 = 4'hC;
`else
    exp_rol1 = 8'h08;
    exp_rol5 = 8'h20;
    exp_rol4 = 4'h0;
`endif
    {se8.start, se8.mode, se8.shamt, se8.iter, se8.data_in, se8.out_ready} = '0;
    {se4.start, se4.mode, se4.shamt, se4.iter, se4.data_in, se4.out_ready} = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(se8.busy), 32'd0);
    check("rst_valid", 32'(se8.out_valid), 32'd0);
    check("rst_data", 32'(se8.data_out), 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    check("pin_lsl", model_result(8'h81, 0, 1, 1, 8), 32'h02);
    check("pin_asr", model_result(8'h90, 2, 2, 2, 8), 32'hF9);
    check("pin_m3", model_result(8'h81, 3, 1, 3, 8), 32'(exp_rol1));
    check("pin_lsr4", model_result(4'h9, 1, 7, 1, 4), 32'h0);
    check("pin_asr4", model_result(4'h9, 2, 7, 1, 4), 32'hF);

    @(negedge clk);
    run_op(8'h81, 2'b00, 3'd1, 4'd1, 8'h02, 0);
    run_op(8'h90, 2'b10, 3'd2, 4'd2, 8'hF9, 0);
    for (int m = 0; m < 4; m++) run_op(8'h5A, 2'(m), 3'd3, 4'd0, 8'h5A, 0);
    run_op(8'hB3, 2'b01, 3'd3, 4'd2, 8'h02, 0);
    run_op(8'h70, 2'b10, 3'd7, 4'd1, 8'h00, 0);
    run_op(8'hC3, 2'b00, 3'd2, 4'd1, 8'h0C, 5);
    run_op(8'h81, 2'b11, 3'd1, 4'd3, exp_rol1, 0);
    run_op(8'h81, 2'b11, 3'd5, 4'd1, exp_rol5, 0);

    // Asynchronous reset in the middle of a long operation.
    se8.start   = 1'b1;
    se8.data_in = 8'hFF;
    se8.mode    = 2'b00;
    se8.shamt   = 3'd1;
    se8.iter    = 4'd15;
    @(posedge clk);
    @(negedge clk);
    se8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(se8.busy), 32'd0);
    check("midrst_valid", 32'(se8.out_valid), 32'd0);
    check("midrst_data", 32'(se8.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(se8.busy), 32'd0);
    run_op(8'h90, 2'b10, 3'd2, 4'd2, 8'hF9, 0);

    run4(4'h9, 2'b01, 3'd7, 4'd1, 4'h0);
    run4(4'h9, 2'b10, 3'd7, 4'd1, 4'hF);
    run4(4'h9, 2'b00, 3'd7, 4'd1, 4'h0);
    run4(4'h6, 2'b10, 3'd1, 4'd2, 4'h1);
    run4(4'h9, 2'b11, 3'd7, 4'd1, exp_rol4);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
